// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first,
// with a start/done handshake and a divide-by-zero fast path.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH:0]   w_next;
  logic             w_qbit;
  logic             w_last;

  // Exact WIDTH+1-bit trial subtract; the extra top bit of the difference is the borrow.
  assign w_shifted              = {r_rem, r_dvd[WIDTH-1]};
  assign {w_borrow, w_trial}    = {1'b0, w_shifted} - {2'b00, r_dsr};
  assign w_next                 = w_borrow ? w_shifted : w_trial;
  assign w_qbit                 = ~w_borrow;
  assign w_last                 = (r_count == CW'(WIDTH - 1));

  // Handshake FSM and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_dvd       <= {WIDTH{1'b0}};
      r_dsr       <= {WIDTH{1'b0}};
      r_rem       <= {WIDTH{1'b0}};
      r_quo       <= {WIDTH{1'b0}};
      r_count     <= {CW{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            if (divisor == {WIDTH{1'b0}}) begin
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_quotient  <= {WIDTH{1'b1}};
              r_remainder <= dividend;
              r_dbz       <= 1'b1;
            end else begin
              r_state <= ST_RUN;
              r_dvd   <= dividend;
              r_dsr   <= divisor;
              r_rem   <= {WIDTH{1'b0}};
              r_quo   <= {WIDTH{1'b0}};
              r_count <= {CW{1'b0}};
            end
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_RUN: begin
          r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
          r_rem   <= WIDTH'(w_next);
          r_quo   <= WIDTH'({r_quo, w_qbit});
          r_count <= r_count + CW'(1);
          if (w_last) begin
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
            r_quotient  <= WIDTH'({r_quo, w_qbit});
            r_remainder <= WIDTH'(w_next);
            r_dbz       <= 1'b0;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed scenarios plus a
// randomized sweep against a plain-arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_pass = 0;
  int n_total = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    if (b == 0) begin
      q = {W{1'b1}}; r = a; dz = 1'b1;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] eq, er, pq, pr;
    logic edz, pdz;
    int cyc;
    bit stable;
    ref_div(a, b, eq, er, edz);
    @(negedge clk);
    pq = quotient; pr = remainder; pdz = div_by_zero;
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    cyc = 1;
    check({tag, " busy"}, busy, 1);
    stable = 1'b1;
    while (!done && cyc < 40) begin
      if (quotient !== pq || remainder !== pr || div_by_zero !== pdz) stable = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, (b == 0) ? 1 : W + 1);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " dbz"}, div_by_zero, edz);
    check({tag, " stable"}, stable, 1);
    @(negedge clk);
    check({tag, " done low"}, done, 0);
    check({tag, " idle"}, busy, 0);
  endtask

  initial begin
    int dones, last, t, pulses;
    logic [W-1:0] a, b, got_q, got_r;

    repeat (2) @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst q", quotient, 0);
    check("rst r", remainder, 0);
    check("rst dbz", div_by_zero, 0);
    rst_n = 1'b1;

    do_op(8'd200, 8'd7, "t1");
    do_op(8'd5, 8'd9, "t2a");
    do_op(8'd255, 8'd1, "t2b");
    do_op(8'd255, 8'd255, "t2c");
    do_op(8'd100, 8'd0, "t3z");
    do_op(8'd200, 8'd7, "t3clr");

    // Start during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    dones = 0; got_q = '0; got_r = '0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin dones++; got_q = quotient; got_r = remainder; end
      @(negedge clk);
    end
    check("t4 dones", dones, 1);
    check("t4 q", got_q, 28);
    check("t4 r", got_r, 4);

    // Reset mid-operation aborts immediately.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5 busy", busy, 0);
    check("t5 done", done, 0);
    check("t5 q", quotient, 0);
    check("t5 r", remainder, 0);
    check("t5 dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'd50, 8'd6, "t5b");

    // Start held high: back-to-back results every W+2 cycles.
    @(negedge clk);
    start = 1'b1; dividend = 8'd13; divisor = 8'd4;
    last = -1; t = 0; pulses = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      t++;
      if (done) begin
        pulses++;
        check("t6 q", quotient, 3);
        check("t6 r", remainder, 1);
        if (last >= 0) check("t6 gap", t - last, W + 2);
        last = t;
      end
    end
    check("t6 pulses", pulses >= 4, 1);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("t6 idle", busy, 0);

    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      do_op(a, b, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
